tx_arbiter: RTL



---
 rtl/tx_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: grants the shared USB transmit path to one packet source at a time.
// Define TX_ARB_HS_PRIORITY_EN to give req[0] strict priority over the round-robin set.
module tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IPG_CYCLES     = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       tx_done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_start,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
  localparam int GAP_LAST_I = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    ACTIVE,
    HOLDOFF
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic [IW-1:0]      last_id_q, last_id_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [NUM_REQ-1:0] rr_req;
  logic               win_vld;
  logic [IW-1:0]      win_id;
  logic [IW:0]        idx;

  // Search starts one past the last owner and wraps.
  always_comb begin
    rr_req  = req;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
`ifdef TX_ARB_HS_PRIORITY_EN
    rr_req[0] = 1'b0;
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (IW+1)'(last_id_q) + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ))
        idx = idx - (IW+1)'(NUM_REQ);
      if (!win_vld && rr_req[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[IW-1:0];
      end
    end
`ifdef TX_ARB_HS_PRIORITY_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_id  = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = GRANT;
          grant_d    = NUM_REQ'(1) << win_id;
          grant_id_d = win_id;
          busy_d     = 1'b1;
`ifdef TX_ARB_HS_PRIORITY_EN
          if (win_id != '0)
            last_id_d = win_id;
`else
          last_id_d = win_id;
`endif
        end
      end
      GRANT: begin
        state_d    = START;
        tx_start_d = 1'b1;
      end
      START: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      ACTIVE: begin
        if (tx_done) begin
          state_d = HOLDOFF;
          grant_d = '0;
          gap_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HOLDOFF;
          grant_d   = '0;
          gap_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLDOFF: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IW'(NUM_REQ - 1);
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
